uart_tx: RTL and testbench

//   Serial transmitter stage directly downstream of the switch/button mux.
//   - Accepts one 8-bit byte per one-cycle `enable` strobe from the mux.
//   - Drives it onto a single `tx` line as an async serial frame:

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between the switch/button mux and the serial transmitter.
interface uart_tx_if;
    logic       enable;
    logic [7:0] data_in;
    logic       ready;
    logic       done;

    modport master (output enable, output data_in, input ready, input done);
    modport slave  (input enable, input data_in, output ready, output done);
endinterface

// File: rtl/uart_tx.sv
// Async serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift, shift_n;
    logic             par, par_n;
    logic             tx_n;
    logic             ready_q, ready_n;
    logic             done_q, done_n;

    assign bus.ready = ready_q;
    assign bus.done  = done_q;

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            par     <= par_n;
            tx      <= tx_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

    // Next-state logic; tx is computed one edge ahead so it changes on bit boundaries.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        par_n   = par;
        tx_n    = tx;
        ready_n = ready_q;
        done_n  = 1'b0;

        if (state != IDLE) begin
            cnt_n = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                if (bus.enable) begin
                    shift_n = bus.data_in;
                    par_n   = ^bus.data_in;
                    cnt_n   = '0;
                    ready_n = 1'b0;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_MAX) begin
                    bit_n   = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_n = '0;
                        if (PARITY_EN != 0) begin
                            tx_n    = par;
                            state_n = PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = shift[1];
                    end
                end
            end
            PARITY: begin
                if (cnt == CNT_MAX) begin
                    bit_n   = '0;
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_MAX) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_n   = '0;
                        ready_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle expected line/handshake values queued per frame.
module tb_uart_tx;

    typedef struct packed {
        logic tx;
        logic ready;
        logic done;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       sel;
    logic [7:0] din;
    logic       tx0, tx1;
    logic       obs_tx, obs_ready, obs_done;

    int    checks = 0;
    int    errors = 0;
    string step   = "init";
    obs_t  exp_q[$];

    uart_tx_if bus0();
    uart_tx_if bus1();

    assign bus0.enable  = en & ~sel;
    assign bus0.data_in = din;
    assign bus1.enable  = en & sel;
    assign bus1.data_in = din;

    assign obs_tx    = sel ? tx1 : tx0;
    assign obs_ready = sel ? bus1.ready : bus0.ready;
    assign obs_done  = sel ? bus1.done : bus0.done;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .tx(tx0)
    );

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .tx(tx1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string field, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %b expected %b", step, field, obs, exp);
        end
    endtask

    task automatic check_obs(input obs_t e);
        check("tx", obs_tx, e.tx);
        check("ready", obs_ready, e.ready);
        check("done", obs_done, e.done);
    endtask

    // Expected per-cycle values from the accepting edge through the done cycle.
    function automatic void push_frame(input logic [7:0] b, input bit parity);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(b[i]);
        if (parity) fb.push_back(^b);
        fb.push_back(1'b1);
        foreach (fb[i]) begin
            for (int c = 0; c < 4; c++) exp_q.push_back('{fb[i], 1'b0, 1'b0});
        end
        exp_q.push_back('{1'b1, 1'b1, 1'b1});
    endfunction

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check_obs('{1'b1, 1'b1, 1'b0});
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the done cycle.
    task automatic send(input bit s, input logic [7:0] b, input bit hold, input bit glitch);
        int k;
        obs_t e;
        k   = 0;
        sel = s;
        en  = 1'b1;
        din = b;
        push_frame(b, s);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_obs(e);
            if (!hold && k == 0) en = 1'b0;
            if (glitch && (k == 10 || k == 25)) begin
                en  = 1'b1;
                din = 8'hFF;
            end
            if (glitch && (k == 11 || k == 26)) en = 1'b0;
            k++;
        end
    endtask

    initial begin
        obs_t e;
        reset = 1'b0;
        en    = 1'b0;
        din   = 8'h00;
        sel   = 1'b0;

        step = "reset";
        idle_check(3);
        reset = 1'b1;
        step = "idle_after_reset";
        idle_check(6);

        step = "send_42";
        send(1'b0, 8'h42, 1'b0, 1'b0);
        step = "idle_after_42";
        idle_check(4);

        step = "par_42";
        send(1'b1, 8'h42, 1'b0, 1'b0);
        step = "par_idle";
        idle_check(2);
        step = "par_07";
        send(1'b1, 8'h07, 1'b0, 1'b0);
        step = "idle_after_07";
        idle_check(4);

        step = "busy_strobe";
        send(1'b0, 8'h42, 1'b0, 1'b1);
        step = "no_second_frame";
        idle_check(20);

        step = "b2b_1";
        send(1'b0, 8'h55, 1'b1, 1'b0);
        step = "b2b_2";
        send(1'b0, 8'h55, 1'b1, 1'b0);
        step = "b2b_3";
        send(1'b0, 8'h55, 1'b0, 1'b0);
        step = "idle_after_b2b";
        idle_check(8);

        // Abort during data bit 3 (edges 16..19 after accept).
        step = "abort_pre";
        en  = 1'b1;
        din = 8'h42;
        push_frame(8'h42, 1'b0);
        @(posedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_obs(e);
            if (k == 0) en = 1'b0;
        end
        exp_q.delete();
        reset = 1'b0;
        step = "abort";
        idle_check(2);
        reset = 1'b1;
        step = "after_abort";
        idle_check(50);
        step = "send_a5";
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        step = "idle_after_a5";
        idle_check(4);

        step = "reset_with_enable";
        reset = 1'b0;
        en    = 1'b1;
        din   = 8'h00;
        idle_check(1);
        reset = 1'b1;
        en    = 1'b0;
        step = "idle_after_reset_en";
        idle_check(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
